// File: rtl/crypto_reduce_pkg.sv
// Shared constants and helpers for the Barrett modular reduction pipeline.
package crypto_reduce_pkg;

    localparam int unsigned Q_DEFAULT       = 3329;
    localparam int          Q_WIDTH_DEFAULT = 16;
    localparam int          PROD_W          = 32;

    // Barrett constant MU = floor(2^32 / q), evaluated at elaboration.
    function automatic logic [PROD_W-1:0] calc_mu(input int unsigned q);
        logic [2*PROD_W-1:0] num;
        logic [2*PROD_W-1:0] quo;
        num = 64'd1 << PROD_W;
        quo = num / {32'd0, q};
        return quo[PROD_W-1:0];
    endfunction

endpackage

// File: rtl/crypto_mod_csub.sv
// Conditional subtract: folds r in [0, 2Q) down to [0, Q).
module crypto_mod_csub
    import crypto_reduce_pkg::*;
#(
    parameter int unsigned Q       = Q_DEFAULT,
    parameter int          Q_WIDTH = Q_WIDTH_DEFAULT
) (
    input  logic [Q_WIDTH:0]   i_r,
    output logic [Q_WIDTH-1:0] o_res
);

    localparam logic [Q_WIDTH:0] Q_EXT = (Q_WIDTH+1)'(Q);

    // Subtract Q once when r has reached or passed it.
    always_comb begin
        o_res = i_r[Q_WIDTH-1:0];
        if (i_r >= Q_EXT) begin
            o_res = Q_WIDTH'(i_r - Q_EXT);
        end
    end

endmodule

// File: rtl/crypto_mod_reduce.sv
// Three-stage Barrett reduction: out_data = in_data mod Q, one item per cycle.
// Optional sticky range check on the result under CRYPTO_MOD_REDUCE_CHECK_EN.
module crypto_mod_reduce
    import crypto_reduce_pkg::*;
#(
    parameter int unsigned Q       = Q_DEFAULT,
    parameter int          Q_WIDTH = Q_WIDTH_DEFAULT
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_WIDTH-1:0] out_data,
    output logic               out_last
`ifdef CRYPTO_MOD_REDUCE_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam logic [PROD_W-1:0] MU  = calc_mu(Q);
    localparam logic [PROD_W-1:0] Q_P = PROD_W'(Q);
    localparam int                R_W = Q_WIDTH + 1;

    logic                  w_en;
    logic                  r_s1_valid;
    logic                  r_s1_last;
    logic [PROD_W-1:0]     r_s1_data;
    logic [2*PROD_W-1:0]   r_s1_prod;
    logic [2*PROD_W-1:0]   w_qhat_q;
    logic [R_W-1:0]        w_r;
    logic                  r_s2_valid;
    logic                  r_s2_last;
    logic [R_W-1:0]        r_s2_r;
    logic [Q_WIDTH-1:0]    w_res;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [Q_WIDTH-1:0]    r_out_data;

    // The whole pipe advances together whenever the output slot can move.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    // qhat*Q never exceeds in_data, so the 64-bit difference is exact and
    // below 2Q; only its low R_W bits are kept.
    assign w_qhat_q = (r_s1_prod >> PROD_W) * {32'd0, Q_P};
    assign w_r      = R_W'({32'd0, r_s1_data} - w_qhat_q);

    crypto_mod_csub #(
        .Q       (Q),
        .Q_WIDTH (Q_WIDTH)
    ) u_csub (
        .i_r   (r_s2_r),
        .o_res (w_res)
    );

    // Valid/last bits and the output register; cleared by reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1_last   <= in_last;
            r_s2_valid  <= r_s1_valid;
            r_s2_last   <= r_s1_last;
            r_out_valid <= r_s2_valid;
            r_out_last  <= r_s2_last;
            r_out_data  <= w_res;
        end
    end

    // Datapath registers for stages 1 and 2; contents only matter when valid.
    always_ff @(posedge ap_clk) begin
        if (w_en) begin
            r_s1_data <= in_data;
            r_s1_prod <= {32'd0, in_data} * {32'd0, MU};
            r_s2_r    <= w_r;
        end
    end

`ifdef CRYPTO_MOD_REDUCE_CHECK_EN
    localparam logic [Q_WIDTH-1:0] Q_RES = Q_WIDTH'(Q);
    logic r_err;

    // Sticky flag: any valid result entering the output stage at or above Q.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_err <= 1'b0;
        end else if (w_en && r_s2_valid && (w_res >= Q_RES)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_crypto_mod_reduce.sv
// Directed and randomised checks of crypto_mod_reduce with Q = 3329.
module tb_crypto_mod_reduce;

    localparam int Q = 3329;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
`ifdef CRYPTO_MOD_REDUCE_CHECK_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_viol = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    bit          bp_done;

    crypto_mod_reduce dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef CRYPTO_MOD_REDUCE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc++;

    // Collect accepted outputs and note any change while stalled.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
                hold_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid === 1'b1 && out_ready === 1'b1)
                obs_q.push_back({out_last, out_data});
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit acc = 0;
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!acc && guard < 200) begin
            @(negedge ap_clk);
            acc = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: data %0d not accepted within 200 cycles", d);
        end
        exp_q.push_back({l, 16'(d % 32'(Q))});
    endtask

    task automatic drain(output bit timed_out);
        int g = 0;
        while (obs_q.size() < exp_q.size() && g < 2000) begin
            tick();
            g++;
        end
        timed_out = (obs_q.size() < exp_q.size());
        repeat (6) tick();
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; in_valid = 1'b1; in_data = 32'd5; in_last = 1'b1; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%0d last=%b required 0/0/0", out_valid, out_data, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        in_valid = 1'b0; ap_rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_input_discard: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_latency();
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'd3328; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early1: got out_valid=%b required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early2: got out_valid=%b required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd3328 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL latency_3328: got valid=%b data=%0d last=%b required 1/3328/1", out_valid, out_data, out_last);
        end
        send(32'd3329, 1'b0);
        tick(); tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL latency_q: got valid=%b data=%0d last=%b required 1/0/0", out_valid, out_data, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] vin [7]  = '{32'd0, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'd0, 32'd6657, 32'd6658, 32'd3328};
        logic [15:0] vexp [7] = '{16'd0, 16'd1352, 16'd113, 16'd0, 16'd3328, 16'd0, 16'd3328};
        bit to;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(vin[i], (i == 6));
        drain(to);
        checks++;
        if (to || obs_q.size() != 7) begin
            errors++;
            $display("FAIL boundary_count: got %0d results required 7", obs_q.size());
        end
        for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== {(i == 6), vexp[i]}) begin
                errors++;
                $display("FAIL boundary_%0d: in %h got data=%0d last=%b required data=%0d last=%b",
                         i, vin[i], obs_q[i][15:0], obs_q[i][16], vexp[i], (i == 6));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, t_send, t_done;
        bit to;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 1000; i++) send($urandom, (i == 999));
        t_send = cyc - t0;
        checks++;
        if (t_send != 1000) begin
            errors++;
            $display("FAIL b2b_accept_rate: got %0d cycles for 1000 items required 1000", t_send);
        end
        drain(to);
        t_done = cyc - t0 - 6;
        checks++;
        if (to || obs_q.size() != 1000 || t_done > 1004) begin
            errors++;
            $display("FAIL b2b_count: got %0d results in %0d cycles required 1000 in <=1004", obs_q.size(), t_done);
        end
        for (int i = 0; i < 1000 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_item_%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
`ifdef CRYPTO_MOD_REDUCE_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err: got %b required 0", err);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit to;
        exp_q.delete(); obs_q.delete();
        hold_viol = 0;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
                    send($urandom, 1'($urandom_range(0, 1)));
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        drain(to);
        checks++;
        if (to || obs_q.size() != 300) begin
            errors++;
            $display("FAIL bp_count: got %0d results required 300", obs_q.size());
        end
        for (int i = 0; i < 300 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_item_%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d output changes while stalled required 0", hold_viol);
        end
    endtask

    task automatic test_reset_midflight();
        bit to;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b0;
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        send(32'd300, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_setup: got out_valid=%b required 1", out_valid);
        end
        ap_rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        ap_rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midflight_stale: got %0d results required 0", obs_q.size());
        end
        send(32'd1234567, 1'b1);
        drain(to);
        checks++;
        if (to || obs_q.size() != 1 || obs_q[0] !== {1'b1, 16'd2837}) begin
            errors++;
            $display("FAIL midflight_next: got %0d results first=%h required 1 result %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'h0, {1'b1, 16'd2837});
        end
    endtask

`ifdef CRYPTO_MOD_REDUCE_CHECK_EN
    task automatic test_err();
        out_ready = 1'b1;
        send(32'd5, 1'b0);
        force dut.r_s2_r = 17'd6658;
        tick(); tick();
        release dut.r_s2_r;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b required 1", err);
        end
        repeat (4) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b required 1", err);
        end
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b required 0", err);
        end
    endtask
`endif

    initial begin
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; ap_rst = 1'b1;
        test_reset();
        test_latency();
        test_boundary();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef CRYPTO_MOD_REDUCE_CHECK_EN
        test_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crypto_mod_reduce.md
CRYPTO_MOD_REDUCE -- requirements
Module: crypto_mod_reduce

Interface
REQ-001 Parameter Q, default 3329; the modulus, 2 <= Q < 2^16.
REQ-002 Parameter Q_WIDTH, default 16; the width of the residue output.
REQ-003 Port ap_clk, input, 1 bit; the single clock, rising edge.
REQ-004 Port ap_rst, input, 1 bit; reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit; the input product is valid.
REQ-006 Port in_ready, output, 1 bit; the block accepts an input this cycle.
REQ-007 Port in_data, input, 32 bits; the unsigned product from the upstream 16x16->32 multiplier.
REQ-008 Port in_last, input, 1 bit; end-of-block marker, carried with the data.
REQ-009 Port out_valid, output, 1 bit; the result is valid.
REQ-010 Port out_ready, input, 1 bit; the downstream stage accepts the result.
REQ-011 Port out_data, output, Q_WIDTH bits; the residue in_data mod Q.
REQ-012 Port out_last, output, 1 bit; the in_last of the same item.
REQ-013 Port err, output, 1 bit; sticky range-check flag, present only under CRYPTO_MOD_REDUCE_CHECK_EN.

Function
REQ-014 Barrett reduction SHALL be used, with MU = floor(2^32 / Q) as an elaboration-time constant (1290167 for Q=3329).
REQ-015 Stage 1 SHALL register in_data and the 64-bit product in_data*MU.
REQ-016 Stage 2 SHALL compute qhat = product[63:32] and register r = in_data - qhat*Q; r SHALL be held as at least Q_WIDTH+1 bits and SHALL satisfy r < 2Q.
REQ-017 Stage 3 SHALL register out_data = (r >= Q) ? r-Q : r, so the result lies in [0, Q-1].
REQ-018 Latency SHALL be exactly 3 ap_clk cycles from the accept edge to out_valid when the output is not stalled.
REQ-019 Throughput SHALL be one item per cycle.
REQ-020 Advance SHALL be en = !out_valid || out_ready; all stages and the valid bits SHALL shift only when en=1.
REQ-021 in_ready SHALL equal en, combinationally; an input is accepted when in_valid && in_ready.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable; no item is dropped or duplicated.
REQ-023 Each stage SHALL carry its own valid bit; bubbles SHALL propagate and never produce out_valid.
REQ-024 in_last SHALL travel with its data; out_last SHALL be meaningful only when out_valid=1.
REQ-025 Boundary values: in_data=0 gives 0; in_data=Q gives 0; in_data=2^32-1 gives (2^32-1) mod Q; no overflow is allowed in any intermediate.

Reset
REQ-026 While ap_rst=1, all stage valid bits, out_valid, out_data, out_last and err SHALL be 0 at the next edge.
REQ-027 Reset mid-operation SHALL discard every in-flight item.
REQ-028 in_ready SHALL read 1 during and after reset, because out_valid=0.

Configuration
REQ-029 Macro CRYPTO_MOD_REDUCE_CHECK_EN defined: a stage-3 comparator SHALL set err when a valid result is >= Q; err is sticky until ap_rst.
REQ-030 Macro CRYPTO_MOD_REDUCE_CHECK_EN undefined: the err port and its logic SHALL be absent, with no other behavioural difference.

Structure
REQ-031 Package crypto_reduce_pkg SHALL hold the Q default, the Q_WIDTH default, the product width (32), and a constant function computing MU from Q.
REQ-032 One sub-module, crypto_mod_csub, SHALL perform the combinational conditional subtract (r, Q -> residue); it SHALL be instanced in stage 3.

Verification
REQ-033 After reset, one item in_data=3328 is driven with out_ready=1: out_data=3328 SHALL appear exactly 3 cycles later, and in_data=3329 SHALL give 0.
REQ-034 in_data=0xFFFFFFFF SHALL give 1352; in_data=0xFFFE0001 (65535*65535) SHALL give 113; in_data=0 SHALL give 0.
REQ-035 1000 back-to-back random items with out_ready=1 SHALL produce results matching a reference model x mod 3329, at 1 item per cycle.
REQ-036 Random out_ready backpressure (50%) plus random in_valid gaps SHALL lose and duplicate no items; outputs SHALL hold while stalled, and in_last SHALL stay aligned.
REQ-037 ap_rst asserted for 1 cycle with 3 items in flight: out_valid SHALL be 0 next cycle, no stale result SHALL emerge, and the next accepted item SHALL be correct.
REQ-038 With CRYPTO_MOD_REDUCE_CHECK_EN defined, err SHALL stay 0 over REQ-035; a force of the stage-2 r to 2Q SHALL set err, and err SHALL stay set until reset.
